// File: rtl/scpad_addr_walker.sv
// rtl/scpad_addr_walker.sv - tile walker emitting one per-bank crossbar descriptor per cycle
// Row-major walks step the slot per descriptor; column-major walks step the slot per bank.
module scpad_addr_walker #(
  parameter int NUM_BANKS     = 32,
  parameter int ROW_IDX_WIDTH = 10,
  parameter int DIM_WIDTH     = $clog2(NUM_BANKS),
  parameter bit SWIZZLE_EN    = 1'b1
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_row_major,
  input  logic [ROW_IDX_WIDTH-1:0]           req_spad_addr,
  input  logic [DIM_WIDTH:0]                 req_num_rows,
  input  logic [DIM_WIDTH:0]                 req_num_cols,
  input  logic                               abort,
  output logic                               desc_valid,
  input  logic                               desc_ready,
  output logic [NUM_BANKS*ROW_IDX_WIDTH-1:0] desc_slot,
  output logic [NUM_BANKS-1:0]               desc_valid_mask,
  output logic [NUM_BANKS*DIM_WIDTH-1:0]     desc_shift,
  output logic [DIM_WIDTH-1:0]               desc_idx,
  output logic                               desc_last,
  output logic                               done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  localparam logic [DIM_WIDTH:0] BANKS_W = (DIM_WIDTH+1)'(NUM_BANKS);
  localparam logic [DIM_WIDTH:0] ONE_W   = (DIM_WIDTH+1)'(1);

  state_t                             state_q, state_d;
  logic                               row_major_q;
  logic [ROW_IDX_WIDTH-1:0]           addr_q;
  logic [DIM_WIDTH:0]                 rows_q, cols_q;
  logic [DIM_WIDTH-1:0]               idx_q;
  logic                               last_q, last_d;
  logic [NUM_BANKS*ROW_IDX_WIDTH-1:0] slot_q, slot_d;
  logic [NUM_BANKS-1:0]               mask_q, mask_d;
  logic [NUM_BANKS*DIM_WIDTH-1:0]     shift_q, shift_d;

  logic                     accept, handshake, load;
  logic [DIM_WIDTH:0]       rows_sat, cols_sat, req_len, walk_len;
  logic                     src_rm;
  logic [ROW_IDX_WIDTH-1:0] src_addr;
  logic [DIM_WIDTH:0]       src_rows, src_cols, src_len;
  logic [DIM_WIDTH-1:0]     src_idx;

  assign rows_sat  = (req_num_rows > BANKS_W) ? BANKS_W : req_num_rows;
  assign cols_sat  = (req_num_cols > BANKS_W) ? BANKS_W : req_num_cols;
  assign req_len   = req_row_major ? rows_sat : cols_sat;
  assign walk_len  = row_major_q ? rows_q : cols_q;
  assign accept    = req_valid & (state_q == S_IDLE);
  assign handshake = (state_q == S_ISSUE) & desc_ready & ~abort;
  assign load      = (accept & (req_len != '0)) | (handshake & ~last_q);

  // The next descriptor comes from the request itself on acceptance, else from the latched walk.
  assign src_rm   = accept ? req_row_major : row_major_q;
  assign src_addr = accept ? req_spad_addr : addr_q;
  assign src_rows = accept ? rows_sat : rows_q;
  assign src_cols = accept ? cols_sat : cols_q;
  assign src_len  = accept ? req_len : walk_len;
  assign src_idx  = accept ? '0 : idx_q + DIM_WIDTH'(1);

  always_comb begin
    logic [ROW_IDX_WIDTH-1:0] abs_v;
    logic [DIM_WIDTH-1:0]     base_v;
    abs_v   = '0;
    base_v  = '0;
    slot_d  = '0;
    mask_d  = '0;
    shift_d = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      abs_v  = src_addr + (src_rm ? ROW_IDX_WIDTH'(src_idx) : ROW_IDX_WIDTH'(b));
      base_v = src_rm ? DIM_WIDTH'(b) : src_idx;
      slot_d[b*ROW_IDX_WIDTH +: ROW_IDX_WIDTH] = abs_v;
      mask_d[b] = (DIM_WIDTH+1)'(b) < (src_rm ? src_cols : src_rows);
      shift_d[b*DIM_WIDTH +: DIM_WIDTH] = SWIZZLE_EN ? (base_v ^ abs_v[DIM_WIDTH-1:0]) : base_v;
    end
    last_d = ((DIM_WIDTH+1)'(src_idx) + ONE_W) == src_len;
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (req_len == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (abort)                    state_d = S_IDLE;
        else if (desc_ready && last_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    desc_valid = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE:  req_ready  = 1'b1;
      S_ISSUE: desc_valid = 1'b1;
      S_DONE:  done       = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_major_q <= 1'b0;
      addr_q      <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      slot_q      <= '0;
      mask_q      <= '0;
      shift_q     <= '0;
    end else begin
      if (accept) begin
        row_major_q <= req_row_major;
        addr_q      <= req_spad_addr;
        rows_q      <= rows_sat;
        cols_q      <= cols_sat;
      end
      if (load) begin
        idx_q   <= src_idx;
        last_q  <= last_d;
        slot_q  <= slot_d;
        mask_q  <= mask_d;
        shift_q <= shift_d;
      end else if (state_q == S_ISSUE && state_d != S_ISSUE) begin
        last_q <= 1'b0;
      end
    end
  end

  assign desc_slot       = slot_q;
  assign desc_valid_mask = mask_q;
  assign desc_shift      = shift_q;
  assign desc_idx        = idx_q;
  assign desc_last       = last_q;

endmodule
